// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NREQ byte sources.
// Grants a byte, pulses tx_start, then follows tx_busy to frame completion or timeout.
module uart_tx_arbiter #(
  parameter int NREQ         = 4,
  parameter int DW           = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      data,
  output logic [NREQ-1:0]         ack,
  output logic                    tx_start,
  output logic [DW-1:0]           tx_data,
  input  logic                    tx_busy,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    active,
  input  logic                    err_clr,
  output logic                    err_timeout,
  output logic [15:0]             sent_cnt
);

  localparam int IW = $clog2(NREQ);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic [NREQ-1:0] ack_reg, ack_next;
  logic            tx_start_reg, tx_start_next;
  logic [DW-1:0]   tx_data_reg, tx_data_next;
  logic [IW-1:0]   grant_id_reg, grant_id_next;
  logic            active_reg, active_next;
  logic            err_timeout_reg, err_timeout_next;
  logic [15:0]     sent_cnt_reg, sent_cnt_next;

  // Modulo-NREQ add; both operands stay below NREQ so one subtraction suffices.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[IW-1:0];
  endfunction

  logic [DW-1:0]   data_arr [NREQ];
  logic [IW-1:0]   cand_idx [NREQ];
  logic [NREQ-1:0] cand_req;

  // cand_* holds the request vector rotated so that slot 0 is the priority pointer.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
    assign data_arr[gi] = data[gi*DW +: DW];
    assign cand_idx[gi] = wrap_add(ptr_reg, 32'(gi));
    assign cand_req[gi] = req[cand_idx[gi]];
  end

  logic          win_valid;
  logic [IW-1:0] win_idx;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand_req[i]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx[i];
      end
    end
  end

  logic [IW-1:0] ptr_after_grant;
  assign ptr_after_grant = wrap_add(grant_id_reg, 32'd1);

  always_comb begin
    state_next       = state_reg;
    ptr_next         = ptr_reg;
    timer_next       = timer_reg;
    ack_next         = '0;
    tx_start_next    = 1'b0;
    tx_data_next     = tx_data_reg;
    grant_id_next    = grant_id_reg;
    active_next      = active_reg;
    err_timeout_next = err_timeout_reg;
    sent_cnt_next    = sent_cnt_reg;

    if (err_clr) err_timeout_next = 1'b0;

    case (state_reg)
      IDLE: begin
        // A busy transmitter here is someone else's frame; just hold off.
        if (!tx_busy && win_valid) begin
          ack_next[win_idx] = 1'b1;
          tx_data_next      = data_arr[win_idx];
          grant_id_next     = win_idx;
          active_next       = 1'b1;
          state_next        = START;
        end
      end
      START: begin
        tx_start_next = 1'b1;
        timer_next    = '0;
        state_next    = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == TW'(BUSY_TIMEOUT - 1)) begin
          err_timeout_next = 1'b1;
          ptr_next         = ptr_after_grant;
          active_next      = 1'b0;
          state_next       = IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          sent_cnt_next = sent_cnt_reg + 16'd1;
          ptr_next      = ptr_after_grant;
          active_next   = 1'b0;
          state_next    = IDLE;
        end
      end
      default: begin
        active_next = 1'b0;
        state_next  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      timer_reg       <= '0;
      ack_reg         <= '0;
      tx_start_reg    <= 1'b0;
      tx_data_reg     <= '0;
      grant_id_reg    <= '0;
      active_reg      <= 1'b0;
      err_timeout_reg <= 1'b0;
      sent_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      timer_reg       <= timer_next;
      ack_reg         <= ack_next;
      tx_start_reg    <= tx_start_next;
      tx_data_reg     <= tx_data_next;
      grant_id_reg    <= grant_id_next;
      active_reg      <= active_next;
      err_timeout_reg <= err_timeout_next;
      sent_cnt_reg    <= sent_cnt_next;
    end
  end

  assign ack         = ack_reg;
  assign tx_start    = tx_start_reg;
  assign tx_data     = tx_data_reg;
  assign grant_id    = grant_id_reg;
  assign active      = active_reg;
  assign err_timeout = err_timeout_reg;
  assign sent_cnt    = sent_cnt_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple transmitter model and a
// grant scoreboard: expected (id, byte) pushed at stimulus, popped at tx_start.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic [1:0]  grant_id;
  logic        active;
  logic        err_clr = 1'b0;
  logic        err_timeout;
  logic [15:0] sent_cnt;

  logic model_en = 1'b1;
  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  logic mpend = 1'b0;
  int   mcnt = 0;

  int compared = 0;
  int mismatched = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] b;
  } exp_t;

  exp_t sb[$];

  assign tx_busy = model_busy | force_busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .BUSY_TIMEOUT(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .data(data),
    .ack(ack),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .tx_busy(tx_busy),
    .grant_id(grant_id),
    .active(active),
    .err_clr(err_clr),
    .err_timeout(err_timeout),
    .sent_cnt(sent_cnt)
  );

  // Transmitter model: busy rises two edges after it sees tx_start, lasts 10 cycles.
  always @(posedge clk) begin
    if (mpend) begin
      mpend      <= 1'b0;
      model_busy <= 1'b1;
      mcnt       <= 10;
    end else if (model_busy) begin
      if (mcnt == 1) model_busy <= 1'b0;
      mcnt <= mcnt - 1;
    end else if (tx_start && model_en) begin
      mpend <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int id, input logic [7:0] b);
    exp_t r;
    r.id = 2'(id);
    r.b  = b;
    return r;
  endfunction

  // Monitor: every ack/tx_start must match the head of the scoreboard.
  logic [3:0] prev_ack = '0;
  logic       prev_start = 1'b0;
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n) begin
      if (ack != 4'b0) begin
        if (sb.size() == 0) check("ack_unexpected", {28'b0, ack}, 32'd0);
        else check("ack_onehot", {28'b0, ack}, 32'd1 << sb[0].id);
        check("ack_width", {28'b0, prev_ack}, 32'd0);
      end
      if (tx_start) begin
        check("start_width", {31'b0, prev_start}, 32'd0);
        if (sb.size() == 0) begin
          check("start_unexpected", {31'b0, tx_start}, 32'd0);
        end else begin
          e = sb.pop_front();
          check("tx_data", {24'b0, tx_data}, {24'b0, e.b});
          check("grant_id", {30'b0, grant_id}, {30'b0, e.id});
          check("ack_before_start", {28'b0, prev_ack}, 32'd1 << e.id);
          $display("frame: grant=%0d data=0x%02h sent_cnt=%0d", grant_id, tx_data, sent_cnt);
        end
      end
    end
    prev_ack   <= rst_n ? ack : 4'b0;
    prev_start <= rst_n ? tx_start : 1'b0;
  end

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, {28'b0, ack}, 32'd0);
    check({tag, "_tx_start"}, {31'b0, tx_start}, 32'd0);
    check({tag, "_tx_data"}, {24'b0, tx_data}, 32'd0);
    check({tag, "_grant_id"}, {30'b0, grant_id}, 32'd0);
    check({tag, "_active"}, {31'b0, active}, 32'd0);
    check({tag, "_err"}, {31'b0, err_timeout}, 32'd0);
    check({tag, "_sent"}, {16'b0, sent_cnt}, 32'd0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero(tag);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int budget, output int idx, output int waited);
    logic got;
    got = 1'b0;
    idx = -1;
    waited = 0;
    while (!got && waited < budget) begin
      @(negedge clk);
      waited++;
      if (ack != 4'b0) begin
        got = 1'b1;
        for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
      end
    end
    check("ack_wait", {31'b0, got}, 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((active || sb.size() != 0 || tx_busy) && w < budget);
    check("idle_wait", {31'b0, (!active && sb.size() == 0 && !tx_busy)}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, w;

    #2 rst_n = 1'b0;
    #1 check_zero("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single request, checks one-cycle grant latency
    data[15:8] = 8'hA7;
    sb.push_back(mk(1, 8'hA7));
    req = 4'b0010;
    wait_ack(20, idx, w);
    check("t1_ack_idx", idx, 1);
    check("t1_latency", w, 1);
    check("t1_active", {31'b0, active}, 32'd1);
    req = 4'b0;
    wait_idle(100);
    check("t1_sent", {16'b0, sent_cnt}, 32'd1);
    check("t1_grant_id", {30'b0, grant_id}, 32'd1);
    check("t1_tx_data_held", {24'b0, tx_data}, 32'hA7);

    // 2: all four request together, served 0..3
    do_reset("t2_rst");
    data = 32'h13121110;
    for (int k = 0; k < 4; k++) sb.push_back(mk(k, 8'h10 + 8'(k)));
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      wait_ack(60, idx, w);
      check("t2_order", idx, k);
      if (idx >= 0) req[idx] = 1'b0;
    end
    wait_idle(100);
    check("t2_sent", {16'b0, sent_cnt}, 32'd4);

    // 3: two requesters hold req high, must alternate
    do_reset("t3_rst");
    data = 32'h88C3775A;
    for (int k = 0; k < 6; k++) sb.push_back(mk((k % 2) * 2, (k % 2) ? 8'hC3 : 8'h5A));
    req = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      wait_ack(60, idx, w);
      check("t3_order", idx, (k % 2) * 2);
      if (k == 5) req = 4'b0;
    end
    wait_idle(100);
    check("t3_sent", {16'b0, sent_cnt}, 32'd6);

    // 4: transmitter never goes busy -> timeout, pointer advance, err_clr
    do_reset("t4_rst");
    model_en = 1'b0;
    data = 32'h99_2C_4B_00;
    sb.push_back(mk(1, 8'h4B));
    req = 4'b0010;
    wait_ack(20, idx, w);
    req = 4'b0;
    w = 0;
    while (!err_timeout && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("t4_timeout_cycles", w, 17);
    check("t4_err", {31'b0, err_timeout}, 32'd1);
    check("t4_active", {31'b0, active}, 32'd0);
    check("t4_sent", {16'b0, sent_cnt}, 32'd0);
    model_en = 1'b1;
    sb.push_back(mk(2, 8'h2C));
    req = 4'b0110;
    wait_ack(20, idx, w);
    check("t4_next_idx", idx, 2);
    req = 4'b0;
    wait_idle(100);
    check("t4_err_sticky", {31'b0, err_timeout}, 32'd1);
    check("t4_sent_after", {16'b0, sent_cnt}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_err_clr", {31'b0, err_timeout}, 32'd0);
    model_en = 1'b0;
    sb.push_back(mk(3, 8'h99));
    req = 4'b1000;
    wait_ack(20, idx, w);
    check("t4_idx3", idx, 3);
    req = 4'b0;
    repeat (16) @(negedge clk);
    check("t4_err_before", {31'b0, err_timeout}, 32'd0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t4_set_wins", {31'b0, err_timeout}, 32'd1);
    wait_idle(50);
    model_en = 1'b1;
    check("t4_sent_final", {16'b0, sent_cnt}, 32'd1);

    // 5: async reset during WAIT_DONE with a pending request
    data = 32'hE5_D2_00_00;
    sb.push_back(mk(2, 8'hD2));
    req = 4'b0100;
    wait_ack(20, idx, w);
    check("t5_idx", idx, 2);
    req = 4'b0;
    w = 0;
    while (!tx_busy && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("t5_busy_seen", {31'b0, tx_busy}, 32'd1);
    @(negedge clk);
    req = 4'b1000;
    force_busy = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("t5_async");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_hold_ack", {28'b0, ack}, 32'd0);
      check("t5_hold_active", {31'b0, active}, 32'd0);
    end
    w = 0;
    while (model_busy && w < 30) begin
      @(negedge clk);
      w++;
    end
    sb.push_back(mk(3, 8'hE5));
    force_busy = 1'b0;
    wait_ack(20, idx, w);
    check("t5_idx3", idx, 3);
    check("t5_latency", w, 1);
    req = 4'b0;
    wait_idle(100);
    check("t5_sent", {16'b0, sent_cnt}, 32'd1);
    check("t5_tx_data", {24'b0, tx_data}, 32'hE5);

    // 6: foreign frame in IDLE holds off arbitration without error
    force_busy = 1'b1;
    data[23:16] = 8'h6E;
    req = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t6_hold_ack", {28'b0, ack}, 32'd0);
      check("t6_no_err", {31'b0, err_timeout}, 32'd0);
    end
    sb.push_back(mk(2, 8'h6E));
    force_busy = 1'b0;
    wait_ack(20, idx, w);
    check("t6_idx", idx, 2);
    check("t6_latency", w, 1);
    req = 4'b0;
    wait_idle(100);
    check("t6_sent", {16'b0, sent_cnt}, 32'd2);
    check("t6_err", {31'b0, err_timeout}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
